// File: rtl/repl_ctrl.sv
// Victim-select and fill-sequencing controller for a 4-way, 4-set cache with 3-bit counters.
// Define REPL_INVALID_FIRST_EN to prefer the lowest-numbered invalid way over the min-counter rule.
module repl_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       miss,
    input  logic [1:0] index,
    input  logic [3:0] valid,
    input  logic [2:0] ctr0,
    input  logic [2:0] ctr1,
    input  logic [2:0] ctr2,
    input  logic [2:0] ctr3,
    input  logic       mem_ack,
    output logic [1:0] fill_index,
    output logic [3:0] index_dec,
    output logic [3:0] way_load,
    output logic [3:0] way_dec,
    output logic       mem_req,
    output logic [1:0] victim,
    output logic       busy,
    output logic       fill_done,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_REQ    = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    logic [1:0] r_state;
    logic [1:0] r_fill_index;
    logic [1:0] r_victim;

    logic [1:0] w_min_way;
    logic [2:0] w_min_val;
    logic [1:0] w_sel_way;
    logic [3:0] w_victim_oh;

    // Strict less-than keeps the lowest way on ties.
    always_comb begin
        w_min_way = 2'd0;
        w_min_val = ctr0;
        if (ctr1 < w_min_val) begin
            w_min_way = 2'd1;
            w_min_val = ctr1;
        end
        if (ctr2 < w_min_val) begin
            w_min_way = 2'd2;
            w_min_val = ctr2;
        end
        if (ctr3 < w_min_val) begin
            w_min_way = 2'd3;
            w_min_val = ctr3;
        end
    end

`ifdef REPL_INVALID_FIRST_EN
    always_comb begin
        w_sel_way = w_min_way;
        if (!valid[0]) begin
            w_sel_way = 2'd0;
        end else if (!valid[1]) begin
            w_sel_way = 2'd1;
        end else if (!valid[2]) begin
            w_sel_way = 2'd2;
        end else if (!valid[3]) begin
            w_sel_way = 2'd3;
        end
    end
`else
    logic w_unused_valid;
    assign w_unused_valid = ^valid;
    assign w_sel_way      = w_min_way;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fill_index <= 2'b00;
            r_victim     <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss) begin
                        r_fill_index <= index;
                        r_state      <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    r_victim <= w_sel_way;
                    r_state  <= S_REQ;
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from registered state so the counter arrays see clean pulses.
    assign w_victim_oh = 4'b0001 << r_victim;
    assign fill_index  = r_fill_index;
    assign index_dec   = 4'b0001 << r_fill_index;
    assign victim      = r_victim;
    assign mem_req     = (r_state == S_REQ);
    assign fill_done   = (r_state == S_UPDATE);
    assign busy        = (r_state != S_IDLE);
    assign way_load    = (r_state == S_UPDATE) ? w_victim_oh : 4'b0000;
    assign way_dec     = (r_state == S_UPDATE) ? (~w_victim_oh & 4'b1111) : 4'b0000;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_repl_ctrl.sv
// Directed bench for repl_ctrl: per-cycle expected-output queue plus literal spot checks.
module tb_repl_ctrl;

    localparam int OW = 19;

    logic       clk;
    logic       reset;
    logic       miss;
    logic [1:0] index;
    logic [3:0] valid;
    logic [2:0] ctr0, ctr1, ctr2, ctr3;
    logic       mem_ack;
    logic [1:0] fill_index;
    logic [3:0] index_dec;
    logic [3:0] way_load;
    logic [3:0] way_dec;
    logic       mem_req;
    logic [1:0] victim;
    logic       busy;
    logic       fill_done;
    logic [1:0] dbg_state;

    repl_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .miss       (miss),
        .index      (index),
        .valid      (valid),
        .ctr0       (ctr0),
        .ctr1       (ctr1),
        .ctr2       (ctr2),
        .ctr3       (ctr3),
        .mem_ack    (mem_ack),
        .fill_index (fill_index),
        .index_dec  (index_dec),
        .way_load   (way_load),
        .way_dec    (way_dec),
        .mem_req    (mem_req),
        .victim     (victim),
        .busy       (busy),
        .fill_done  (fill_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [OW-1:0] exp_q[$];
    logic [1:0]    idle_fi  = 2'b00;
    logic [1:0]    idle_vic = 2'b00;
    logic          chk_en   = 1'b0;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            fd_cnt   = 0;
    int            upd_cyc  = 0;
    int            miss_cyc = 0;
    logic [3:0]    cap_wl   = 4'b0;
    logic [3:0]    cap_wd   = 4'b0;
    logic [1:0]    cap_vic  = 2'b0;

    // Expected output vector: {fill_index, index_dec, way_load, way_dec, mem_req, victim, busy, fill_done}
    function automatic logic [OW-1:0] mk(input logic [1:0] fi, input logic upd,
                                         input logic mreq, input logic [1:0] vic,
                                         input logic bsy);
        logic [3:0] idec;
        logic [3:0] oh;
        logic [3:0] wl;
        logic [3:0] wd;
        idec = 4'b0001 << fi;
        oh   = 4'b0001 << vic;
        wl   = upd ? oh : 4'b0000;
        wd   = upd ? (~oh & 4'b1111) : 4'b0000;
        return {fi, idec, wl, wd, mreq, vic, bsy, upd};
    endfunction

    // Victim from the replacement rules: first invalid way (if enabled), else first way holding the minimum.
    function automatic logic [1:0] model_victim(input int c[4], input logic [3:0] vld);
        int mn;
`ifdef REPL_INVALID_FIRST_EN
        for (int w = 0; w < 4; w++) begin
            if (!vld[w]) return 2'(w);
        end
`else
        if (vld == 4'hF) mn = 0;
`endif
        mn = 8;
        for (int w = 0; w < 4; w++) if (c[w] < mn) mn = c[w];
        for (int w = 0; w < 4; w++) if (c[w] == mn) return 2'(w);
        return 2'd0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            logic [OW-1:0] e;
            logic [OW-1:0] a;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(idle_fi, 1'b0, 1'b0, idle_vic, 1'b0);
            a = {fill_index, index_dec, way_load, way_dec, mem_req, victim, busy, fill_done};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs cycle %0d: got %b expected %b", cyc, a, e);
            if (fill_done === 1'b1) begin
                fd_cnt++;
                upd_cyc = cyc;
                cap_wl  = way_load;
                cap_wd  = way_dec;
                cap_vic = victim;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            index   = 2'($urandom_range(0, 3));
            step();
        end
        mem_ack = 1'b0;
    endtask

    // Starts at the beginning of an IDLE cycle, returns at the start of the IDLE cycle after UPDATE.
    task automatic do_fill(input logic [1:0] idx, input int c0, input int c1, input int c2,
                           input int c3, input logic [3:0] vld, input int ack_wait,
                           input logic stray);
        int         c[4];
        logic [1:0] v;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        v = model_victim(c, vld);
        miss_cyc = cyc;
        exp_q.push_back(mk(idle_fi, 1'b0, 1'b0, idle_vic, 1'b0));
        exp_q.push_back(mk(idx, 1'b0, 1'b0, idle_vic, 1'b1));
        for (int k = 0; k <= ack_wait; k++) exp_q.push_back(mk(idx, 1'b0, 1'b1, v, 1'b1));
        exp_q.push_back(mk(idx, 1'b1, 1'b0, v, 1'b1));
        idle_fi  = idx;
        idle_vic = v;
        ctr0 = 3'(c0); ctr1 = 3'(c1); ctr2 = 3'(c2); ctr3 = 3'(c3);
        valid   = vld;
        miss    = 1'b1;
        index   = idx;
        mem_ack = 1'b0;
        step();
        miss    = 1'b0;
        index   = idx ^ 2'b11;
        mem_ack = 1'b1;
        step();
        for (int k = 0; k <= ack_wait; k++) begin
            mem_ack = (k == ack_wait);
            miss    = stray && (k == 0);
            step();
        end
        miss    = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    // Abandon a fill with reset while in REQ; miss is also raised with reset.
    task automatic do_fill_reset(input logic [1:0] idx);
        exp_q.push_back(mk(idle_fi, 1'b0, 1'b0, idle_vic, 1'b0));
        exp_q.push_back(mk(idx, 1'b0, 1'b0, idle_vic, 1'b1));
        exp_q.push_back(mk(idx, 1'b0, 1'b1, 2'd3, 1'b1));
        exp_q.push_back(mk(idx, 1'b0, 1'b1, 2'd3, 1'b1));
        exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 2'd0, 1'b0));
        idle_fi  = 2'd0;
        idle_vic = 2'd0;
        ctr0 = 3'd5; ctr1 = 3'd4; ctr2 = 3'd6; ctr3 = 3'd1;
        valid   = 4'hF;
        miss    = 1'b1;
        index   = idx;
        step();
        miss = 1'b0;
        step();
        step();
        reset = 1'b1;
        miss  = 1'b1;
        step();
        reset = 1'b0;
        miss  = 1'b0;
    endtask

    initial begin
        int fd_before;
        reset   = 1'b1;
        miss    = 1'b0;
        index   = 2'd0;
        valid   = 4'hF;
        ctr0 = 3'd0; ctr1 = 3'd0; ctr2 = 3'd0; ctr3 = 3'd0;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_index_dec", int'(index_dec), 1);
        step();
        reset = 1'b0;
        idle_cycles(4);
        chk("idle_no_fill_done", fd_cnt, 0);

        fd_cnt = 0;
        do_fill(2'd2, 3, 5, 1, 7, 4'hF, 1, 1'b0);
        chk("t1_victim", int'(cap_vic), 2);
        chk("t1_way_load", int'(cap_wl), 4'b0100);
        chk("t1_way_dec", int'(cap_wd), 4'b1011);
        chk("t1_fill_done_cnt", fd_cnt, 1);
        chk("t1_update_cycle", upd_cyc - miss_cyc, 4);
        chk("t1_fill_index", int'(fill_index), 2);
        chk("t1_index_dec", int'(index_dec), 4'b0100);
        idle_cycles(2);

        do_fill(2'd1, 2, 2, 2, 2, 4'hF, 0, 1'b0);
        chk("tie_victim", int'(cap_vic), 0);
        do_fill(2'd3, 7, 4, 4, 6, 4'hF, 0, 1'b0);
        chk("tie2_victim", int'(cap_vic), 1);
        chk("b2b_update_cycle", upd_cyc - miss_cyc, 3);

        do_fill(2'd0, 1, 6, 3, 2, 4'hF, 2, 1'b1);
        chk("stray_fill_index", int'(fill_index), 0);
        chk("stray_victim", int'(victim), 0);
        idle_cycles(1);

        fd_before = fd_cnt;
        do_fill_reset(2'd3);
        idle_cycles(3);
        chk("reset_req_no_fill_done", fd_cnt, fd_before);
        chk("reset_req_mem_req", int'(mem_req), 0);

        do_fill(2'd1, 0, 7, 7, 7, 4'b1011, 0, 1'b0);
`ifdef REPL_INVALID_FIRST_EN
        chk("valid_victim", int'(cap_vic), 2);
`else
        chk("valid_victim", int'(cap_vic), 0);
`endif
        idle_cycles(4);
        chk("queue_drained", exp_q.size(), 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/repl_ctrl.md
# repl_ctrl

Per-cache replacement controller for the 4-way, 4-set phased cache. On a miss reported by the tag-compare phase it reads the indexed counter of every way's counter array and selects a victim way. It runs a request/acknowledge fill handshake with memory, then issues a one-cycle load to the victim way's counter and a decrement to all other ways' counters. It sits directly downstream of the four counter arrays, consumes their selected outputs, and generates their index, decrement and load controls.

## Interface
- No parameters; 4 ways, 4 sets, 3-bit counters are fixed.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- miss  in  1  one-cycle pulse from tag-compare phase; sampled only in IDLE
- index  in  2  set index accompanying miss
- valid  in  4  per-way valid bit of the set addressed by fill_index
- ctr0, ctr1, ctr2, ctr3  in  3 each  selected counter output of way 0..3 for the set addressed by fill_index
- mem_ack  in  1  memory fill complete; sampled only in REQ
- fill_index  out  2  latched miss index; drives the index input of all four counter arrays
- index_dec  out  4  one-hot decode of fill_index, shared by all four counter arrays
- way_load  out  4  per-way load strobe (counter set to 3'b111)
- way_dec  out  4  per-way decrement strobe
- mem_req  out  1  fill request to memory
- victim  out  2  selected victim way, registered
- busy  out  1  controller not in IDLE; upstream must stall and must not pulse miss
- fill_done  out  1  one-cycle pulse when the fill completes

## Operation
- FSM states: IDLE, SELECT, REQ, UPDATE.
- IDLE:
  - If miss=1: latch fill_index<=index and go to SELECT.
  - Otherwise stay in IDLE.
- SELECT (exactly 1 cycle):
  - ctr0..ctr3 and valid now reflect the latched fill_index.
  - Compute the victim and register it into victim. Go to REQ.
- Victim rule: the way with the minimum counter value, compared unsigned 0..7. On a tie, the lowest way number wins.
- REQ:
  - mem_req=1.
  - Stay in REQ until mem_ack=1, then go to UPDATE.
- UPDATE (exactly 1 cycle):
  - way_load = one-hot(victim).
  - way_dec = ~one-hot(victim) & 4'b1111.
  - fill_done=1.
  - Go to IDLE.
- index_dec = one-hot(fill_index) continuously, combinational from the register. The counter arrays gate it with way_load/way_dec, so only the latched set is affected.
- way_load, way_dec, mem_req and fill_done are combinational decodes of state and are glitch-free at registers.
- Ignored inputs:
  - miss is ignored outside IDLE.
  - mem_ack is ignored outside REQ.
- Reset values (any state, including mid-fill):
  - state=IDLE, fill_index=2'b00, victim=2'b00.
  - index_dec=4'b0001.
  - way_load=4'b0000, way_dec=4'b0000.
  - mem_req=0, busy=0, fill_done=0.
- Reset in REQ drops mem_req in the following cycle; the fill is abandoned.
- miss and reset asserted together: reset wins.

## Timing
- miss sampled at edge 0 -> SELECT in cycle 1 -> mem_req high from cycle 2.
- mem_ack high in cycle n (n≥2) -> UPDATE in cycle n+1 (way_load/way_dec/fill_done high) -> IDLE in cycle n+2.
- Minimum miss-to-load latency is 3 cycles (mem_ack=1 in the first REQ cycle).
- busy is high from cycle 1 through UPDATE inclusive.
- A new miss is accepted in the first IDLE cycle after UPDATE.
- Counter arrays see the load/dec on the edge ending UPDATE. The victim's counter reads 3'b111 from cycle n+2.

## Configuration
- REPL_INVALID_FIRST_EN defined:
  - In SELECT, if any valid bit is 0, victim = lowest-numbered invalid way; counters are ignored.
  - If all ways are valid, the min-counter rule applies.
- REPL_INVALID_FIRST_EN undefined: valid is ignored entirely; min-counter rule always.

## Test plan
- Reset, then idle: all outputs at reset values; index_dec=4'b0001; mem_ack pulses in IDLE cause no state change.
- miss, index=2, ctr={3,5,1,7}, mem_ack on the 2nd REQ cycle:
  - fill_index=2, index_dec=4'b0100, victim=2.
  - UPDATE at cycle 4 with way_load=4'b0100, way_dec=4'b1011, one fill_done pulse.
- Tie: ctr={2,2,2,2} -> victim=0. Then ctr={7,4,4,6} -> victim=1.
- Back-to-back:
  - A second miss during REQ is ignored.
  - A miss on the first IDLE cycle after UPDATE is accepted; SELECT follows in the next cycle.
- Reset asserted while in REQ with mem_req=1:
  - Next cycle: IDLE, mem_req=0, way_load=0, way_dec=0, no fill_done.
- With REPL_INVALID_FIRST_EN, valid=4'b1011, ctr={0,7,7,7}:
  - victim=2.
  - Without the macro, same stimulus -> victim=0.
